// File: rtl/fc_l2_arb_pkg.sv
// Package fc_l2_arb_pkg
// Purpose : shared types and helpers for the FC L2 port arbiter slice.
//   arb_state_e : arbiter FSM state (IDLE, LOCKED)
//   clog2_min1  : max(1, $clog2(n)), so that index vectors are never zero-width
package fc_l2_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// Module fc_l2_arb_id_fifo
// Purpose : in-order FIFO holding the owner index of each granted-but-unanswered
//           L2 transaction. Pointer based; DEPTH must be a power of 2.
// Ports   :
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  : write wdata when push=1 (ignored while full)
//   pop          : drop the head entry (ignored while empty)
//   rdata        : head entry, valid while empty=0
//   full, empty  : occupancy flags
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = clog2_min1(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Module fc_l2_port_arbiter
// Purpose : shares one FC L2 data port (TCDM req/gnt/r_valid) between N_REQ
//           requesters. Round-robin arbitration; the selection is locked while a
//           request waits for l2_gnt_i. Owners of granted transactions are kept in
//           an in-order ID FIFO and responses are routed back to them.
// Ports   :
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   req_i/add_i/wen_i/wdata_i/be_i    per-requester request side (flattened)
//   gnt_o, r_valid_o                  per-requester grant and response valid
//   r_rdata_o, r_opc_o                response data/error shared by all requesters
//   l2_req_o ... l2_be_o, l2_gnt_i    L2 request side
//   l2_r_valid_i/rdata/opc            L2 response side
//   orphan_rsp_o                      sticky: response seen with nothing outstanding
// Optional (macro FC_L2_ARB_PERF_EN):
//   perf_clr_i                        synchronous clear of stall counters
//   stall_cnt_o [N_REQ*16]            saturating per-requester stall cycle counts
// Handshake: a requester holds req_i[k] and its payload stable until gnt_o[k];
//   a transfer happens in the cycle where gnt_o[k]=1. r_valid_o[k] is a one-cycle
//   strobe with no back-pressure.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   add_i,
    input  logic [N_REQ-1:0]          wen_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] be_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          r_valid_o,
    output logic [DATA_W-1:0]         r_rdata_o,
    output logic                      r_opc_o,
    output logic                      l2_req_o,
    output logic [ADDR_W-1:0]         l2_add_o,
    output logic                      l2_wen_o,
    output logic [DATA_W-1:0]         l2_wdata_o,
    output logic [DATA_W/8-1:0]       l2_be_o,
    input  logic                      l2_gnt_i,
    input  logic                      l2_r_valid_i,
    input  logic [DATA_W-1:0]         l2_r_rdata_i,
    input  logic                      l2_r_opc_i,
    output logic                      orphan_rsp_o
`ifdef FC_L2_ARB_PERF_EN
    ,
    input  logic                      perf_clr_i,
    output logic [N_REQ*16-1:0]       stall_cnt_o
`endif
);

    localparam int IW   = clog2_min1(N_REQ);
    localparam int BE_W = DATA_W / 8;
    typedef logic [IW-1:0] idx_t;

    arb_state_e state;      // FSM state, kept as a named signal for checkers
    idx_t       sel;        // locked owner while waiting for l2_gnt_i
    idx_t       rr_ptr;
    idx_t       win;
    idx_t       cur;
    idx_t       head;
    logic       win_found;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    function automatic idx_t next_idx(input idx_t k);
        if (int'(k) == N_REQ - 1) return '0;
        return k + idx_t'(1);
    endfunction

    // Round-robin search starting at rr_ptr. A full FIFO removes every candidate,
    // even when a pop happens in the same cycle.
    always_comb begin
        int j;
        j         = 0;
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!win_found && !fifo_full && req_i[j]) begin
                win_found = 1'b1;
                win       = idx_t'(j);
            end
        end
    end

    // Request path is purely combinational; payload is forced to 0 when idle.
    always_comb begin
        cur        = (state == LOCKED) ? sel : win;
        l2_req_o   = (state == LOCKED) || win_found;
        gnt_o      = '0;
        l2_add_o   = '0;
        l2_wen_o   = 1'b0;
        l2_wdata_o = '0;
        l2_be_o    = '0;
        if (l2_req_o) begin
            l2_add_o   = add_i[int'(cur)*ADDR_W +: ADDR_W];
            l2_wen_o   = wen_i[cur];
            l2_wdata_o = wdata_i[int'(cur)*DATA_W +: DATA_W];
            l2_be_o    = be_i[int'(cur)*BE_W +: BE_W];
            if (l2_gnt_i) gnt_o[cur] = 1'b1;
        end
    end

    assign push = l2_req_o && l2_gnt_i;
    assign pop  = l2_r_valid_i && !fifo_empty;

    // Response path: data/error pass straight through; valid is steered to the owner.
    always_comb begin
        r_valid_o = '0;
        if (pop) r_valid_o[head] = 1'b1;
    end
    assign r_rdata_o = l2_r_rdata_i;
    assign r_opc_o   = l2_r_opc_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            sel          <= '0;
            rr_ptr       <= '0;
            orphan_rsp_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        if (l2_gnt_i) begin
                            rr_ptr <= next_idx(win);
                        end else begin
                            sel   <= win;
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (l2_gnt_i) begin
                        rr_ptr <= next_idx(sel);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (l2_r_valid_i && fifo_empty) orphan_rsp_o <= 1'b1;
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (IW)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (cur),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef FC_L2_ARB_PERF_EN
    for (genvar k = 0; k < N_REQ; k++) begin : g_stall
        logic [15:0] cnt;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (perf_clr_i) begin
                cnt <= '0;
            end else if (req_i[k] && !gnt_o[k] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign stall_cnt_o[k*16 +: 16] = cnt;
    end
`endif

endmodule
